// File: rtl/core_pkg.sv
// Shared register-index types for the decode scoreboard slice.
// Optional build macro used by this slice: SCOREBOARD_STATS_EN.
package core_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [NUM_REGS-1:0]  reg_mask_t;

    function automatic reg_mask_t onehot(input reg_idx_t idx);
        reg_mask_t m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/decode_scoreboard_if.sv
// Decoder -> scoreboard -> issue handshake plus dcache ack bundle.
// master = decoder/dcache side, slave = scoreboard.
interface decode_scoreboard_if;
    import core_pkg::*;

    logic     dec_valid;
    logic     dec_retry;
    reg_idx_t dec_rs1;
    reg_idx_t dec_rs2;
    reg_idx_t dec_rd;
    logic     dec_use_rs1;
    logic     dec_use_rs2;
    logic     dec_writes_rd;
    logic     dec_is_load;
    logic     iss_valid;
    logic     iss_retry;
    logic     dcache_ack_valid;
    reg_idx_t dcache_ack_rd;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd,
        output dec_use_rs1, dec_use_rs2,
        output dec_writes_rd, dec_is_load,
        output iss_retry, dcache_ack_valid, dcache_ack_rd,
        input  dec_retry, iss_valid
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd,
        input  dec_use_rs1, dec_use_rs2,
        input  dec_writes_rd, dec_is_load,
        input  iss_retry, dcache_ack_valid, dcache_ack_rd,
        output dec_retry, iss_valid
    );

endinterface

// File: rtl/sb_pending_mask.sv
// Pending-register bitmap: set/clear per cycle, set wins on the same index.
// Register 0 has no flop and always reads as not pending.
module sb_pending_mask
    import core_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      set_en,
    input  reg_idx_t  set_idx,
    input  logic      clr_en,
    input  reg_idx_t  clr_idx,
    output reg_mask_t mask
);

    logic [NUM_REGS-1:1] bits_q;
    reg_mask_t           nxt;

    always_comb begin
        nxt = mask;
        if (clr_en) nxt = nxt & ~onehot(clr_idx);
        if (set_en) nxt = nxt | onehot(set_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) bits_q <= '0;
        else       bits_q <= nxt[NUM_REGS-1:1];
    end

    assign mask = {bits_q, 1'b0};

endmodule

// File: rtl/decode_scoreboard.sv
// Load-use hazard gate between decoder and regfile/execute.
// Define SCOREBOARD_STATS_EN to build the hazard stall counter.
module decode_scoreboard
    import core_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    decode_scoreboard_if.slave   bus,
    output reg_mask_t            pending_mask,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 ack_err,
    output logic [31:0]          stall_cycles
);

    reg_mask_t ack_mask;
    reg_mask_t eff_pend;
    logic      hazard;
    logic      full;
    logic      fire;
    logic      load_fire;
    logic      set_en;
    logic      ack;

    assign ack      = bus.dcache_ack_valid & ~reset;
    assign ack_mask = bus.dcache_ack_valid ? onehot(bus.dcache_ack_rd) : '0;
    // A same-cycle ack resolves the hazard: the regfile forwards its data.
    assign eff_pend = pending_mask & ~ack_mask;

    assign hazard = (bus.dec_use_rs1   & eff_pend[bus.dec_rs1])
                  | (bus.dec_use_rs2   & eff_pend[bus.dec_rs2])
                  | (bus.dec_writes_rd & eff_pend[bus.dec_rd]);

    assign full = bus.dec_is_load
                & (outstanding == CNT_W'(MAX_OUTSTANDING))
                & ~bus.dcache_ack_valid;

    assign fire = ~reset & bus.dec_valid & ~hazard
                & ~full & ~bus.iss_retry;

    assign bus.iss_valid = fire;
    assign bus.dec_retry = reset | (bus.dec_valid & ~fire);

    assign load_fire = fire & bus.dec_is_load;
    assign set_en    = load_fire & bus.dec_writes_rd
                     & (bus.dec_rd != '0);

    sb_pending_mask u_pend (
        .clk     (clk),
        .reset   (reset),
        .set_en  (set_en),
        .set_idx (bus.dec_rd),
        .clr_en  (ack),
        .clr_idx (bus.dcache_ack_rd),
        .mask    (pending_mask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            unique case ({load_fire, ack})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01: begin
                    if (outstanding != '0)
                        outstanding <= outstanding - 1'b1;
                end
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Ack for a register nobody is waiting on, or with nothing in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_err <= 1'b0;
        end else if (ack) begin
            if (((bus.dcache_ack_rd != '0)
                 & ~pending_mask[bus.dcache_ack_rd])
                | (outstanding == '0))
                ack_err <= 1'b1;
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= '0;
        else if (bus.dec_valid & hazard)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
